// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: turns one RV32I load/store request into
// single-cycle memory strobes (with read-modify-write for sub-word stores)
// and returns a one-cycle response with extended load data or an error flag.
module lsu_mem_master #(
    parameter int ADDR_W   = 10,
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [WORDSIZE-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORDSIZE-1:0] resp_rdata,
    output logic                resp_err,
    output logic                mem_wren,
    output logic                mem_rden,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORDSIZE-1:0] mem_d,
    input  logic [WORDSIZE-1:0] mem_q
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;
    logic [31:0]       st_repl;
    logic [3:0]        lane_en;
    logic [31:0]       st_word;

    assign accept = (state_q == IDLE) && req_valid;

    // Classify the incoming request: alignment, width code legality, range.
    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = |req_addr[1:0];
            3'b100:  req_err = req_we;
            3'b101:  req_err = req_we | req_addr[0];
            default: req_err = 1'b1;
        endcase
        if ((req_addr >> (ADDR_W + 2)) != 32'd0) begin
            req_err = 1'b1;
        end
    end

    // State register plus request capture and read-data capture at the end of RD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            word_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[ADDR_W+1:0];
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
            if (state_q == RD) begin
                word_q <= mem_q;
            end
        end
    end

    // Load result: pick the addressed byte/half (little-endian) and extend.
    always_comb begin
        ld_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = word_q;
        endcase
    end

    // Store data replicated across lanes so each lane can simply pick it up.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   st_repl = {4{wdata_q[7:0]}};
            2'b01:   st_repl = {2{wdata_q[15:0]}};
            default: st_repl = wdata_q;
        endcase
    end

    // Per-lane merge: replaced lanes take store data, others keep the read word.
    // A full-word store enables every lane, so the stale captured word never leaks.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_en[gi] = (funct3_q[1:0] == 2'b00) ? (addr_q[1:0] == LANE) :
                                 (funct3_q[1:0] == 2'b01) ? (addr_q[1] == LANE[1]) :
                                 1'b1;
            assign st_word[8*gi +: 8] = lane_en[gi] ? st_repl[8*gi +: 8] : word_q[8*gi +: 8];
        end
    endgenerate

    // Next state and strobes; everything is forced quiet while reset is held.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_rden   = 1'b0;
        mem_wren   = 1'b0;
        mem_d      = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_we && (req_funct3 == 3'b010)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                mem_rden = 1'b1;
                state_d  = we_q ? WR : RESP;
            end
            WR: begin
                mem_wren = 1'b1;
                mem_d    = st_word;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !we_q) begin
                    resp_rdata = ld_data;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            req_ready  = 1'b0;
            mem_rden   = 1'b0;
            mem_wren   = 1'b0;
            mem_d      = '0;
            resp_valid = 1'b0;
            resp_err   = 1'b0;
            resp_rdata = '0;
        end
    end

    assign mem_addr = addr_q[ADDR_W+1:2];

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural word memory.
module tb_lsu_mem_master;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_wren;
    logic          mem_rden;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_d;
    logic [31:0]   mem_q;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:1023];
    logic        mem_init_done = 1'b0;

    int          lat, nrd, nwr;
    logic [31:0] rd, wdat, maddr;
    logic        err, rdy;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(AW), .WORDSIZE(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_wren   (mem_wren),
        .mem_rden   (mem_rden),
        .mem_addr   (mem_addr),
        .mem_d      (mem_d),
        .mem_q      (mem_q)
    );

    // Memory model: preload once, then accept writes on the clock edge.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[3] <= 32'h11223344;
            mem[4] <= 32'h0BADF00D;
            mem[5] <= 32'h8899AABB;
            mem_init_done <= 1'b1;
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_d;
        end
    end

    // Garbage when not reading, so a capture in the wrong cycle shows up.
    assign mem_q = mem_rden ? mem[mem_addr] : 32'h5A5A5A5A;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe exclusivity and idle write data, every cycle.
    always @(negedge clk) begin
        if (mem_init_done) begin
            chk("mon_excl", {31'd0, mem_wren & mem_rden}, 32'd0);
            if (!mem_wren) chk("mon_memd_idle", mem_d, 32'd0);
            if (resp_valid) chk("mon_resp_strobes", {30'd0, mem_wren, mem_rden}, 32'd0);
        end
    end

    // One request: present for one cycle, then wait (bounded) for the response.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        rdy   = req_ready;
        lat   = 0;
        rd    = 32'hFFFF_FFFF;
        err   = 1'bx;
        nrd   = 0;
        nwr   = 0;
        wdat  = 32'd0;
        maddr = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (mem_rden) nrd++;
            if (mem_wren) begin
                nwr++;
                wdat = mem_d;
            end
            if (mem_rden || mem_wren) maddr = 32'(mem_addr);
            if (resp_valid) begin
                lat = i;
                rd  = resp_rdata;
                err = resp_err;
                break;
            end
            @(negedge clk);
        end
        $display("txn we=%0d f3=%03b addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d rd=%0d wr=%0d",
                 we, f3, a, wd, lat, rd, err, nrd, nwr);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp);
        txn(1'b0, f3, a, 32'd0);
        chk({tag, "_ready"}, {31'd0, rdy}, 32'd1);
        chk({tag, "_lat"}, lat, 32'd2);
        chk({tag, "_rdata"}, rd, exp);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_strobes"}, {nrd[15:0], nwr[15:0]}, {16'd1, 16'd0});
        chk({tag, "_maddr"}, maddr, {22'd0, a[11:2]});
    endtask

    task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a);
        txn(we, f3, a, 32'h12345678);
        chk({tag, "_lat"}, lat, 32'd1);
        chk({tag, "_err"}, {31'd0, err}, 32'd1);
        chk({tag, "_rdata"}, rd, 32'd0);
        chk({tag, "_strobes"}, {nrd[15:0], nwr[15:0]}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        chk("rst_strobes", {30'd0, mem_wren, mem_rden}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_maddr", {22'd0, mem_addr}, 32'd0);
        chk("rst_memd", mem_d, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

        // Loads from word 5 = 0x8899AABB
        do_load("lb_16",  3'b000, 32'h16, 32'hFFFFFF99);
        do_load("lhu_16", 3'b101, 32'h16, 32'h00008899);
        do_load("lh_14",  3'b001, 32'h14, 32'hFFFFAABB);
        do_load("lbu_17", 3'b100, 32'h17, 32'h00000088);
        do_load("lb_14",  3'b000, 32'h14, 32'hFFFFFFBB);
        do_load("lw_14",  3'b010, 32'h14, 32'h8899AABB);

        // SB read-modify-write into word 3 = 0x11223344
        txn(1'b1, 3'b000, 32'h0D, 32'hDEADBEEF);
        chk("sb_lat", lat, 32'd3);
        chk("sb_strobes", {nrd[15:0], nwr[15:0]}, {16'd1, 16'd1});
        chk("sb_memd", wdat, 32'h1122EF44);
        chk("sb_maddr", maddr, 32'd3);
        chk("sb_err", {31'd0, err}, 32'd0);
        chk("sb_rdata", rd, 32'd0);
        do_load("lw_0c", 3'b010, 32'h0C, 32'h1122EF44);

        // SH into the upper half of the same word
        txn(1'b1, 3'b001, 32'h0E, 32'hFFFF1234);
        chk("sh_lat", lat, 32'd3);
        chk("sh_memd", wdat, 32'h1234EF44);
        do_load("lhu_0e", 3'b101, 32'h0E, 32'h00001234);

        // Illegal / misaligned / out of range
        do_err("lw_mis",   1'b0, 3'b010, 32'h02);
        do_err("sh_mis",   1'b1, 3'b001, 32'h03);
        do_err("f3_011",   1'b0, 3'b011, 32'h00);
        do_err("f3_110",   1'b0, 3'b110, 32'h00);
        do_err("range",    1'b0, 3'b010, 32'h00001000);
        do_err("st_f3bu",  1'b1, 3'b100, 32'h04);

        // SW with req_valid held: no acceptance until IDLE comes back
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h08; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        chk("swh_ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        chk("swh_ready_wr", {31'd0, req_ready}, 32'd0);
        chk("swh_wren", {31'd0, mem_wren}, 32'd1);
        chk("swh_memd", mem_d, 32'hCAFEF00D);
        chk("swh_maddr", {22'd0, mem_addr}, 32'd2);
        @(negedge clk);
        chk("swh_ready_resp", {31'd0, req_ready}, 32'd0);
        chk("swh_resp", {30'd0, resp_valid, resp_err}, 32'd2);
        chk("swh_wren_resp", {31'd0, mem_wren}, 32'd0);
        @(negedge clk);
        chk("swh_ready_idle2", {31'd0, req_ready}, 32'd1);
        chk("swh_wren_idle2", {31'd0, mem_wren}, 32'd0);
        @(negedge clk);
        chk("swh_second_wr", {31'd0, mem_wren}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("swh_second_resp", {31'd0, resp_valid}, 32'd1);
        $display("txn held SW addr=00000008 wdata=cafef00d completed twice");
        do_load("lw_08", 3'b010, 32'h08, 32'hCAFEF00D);

        // Reset during RD of an SH: no write, no response
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h12; req_wdata = 32'h00005555;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rsh_in_rd", {31'd0, mem_rden}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rsh_rden_cut", {31'd0, mem_rden}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rsh_strobes", {30'd0, mem_wren, mem_rden}, 32'd0);
            chk("rsh_resp", {30'd0, resp_valid, resp_err}, 32'd0);
            chk("rsh_rdata", resp_rdata, 32'd0);
            chk("rsh_memd", mem_d, 32'd0);
            chk("rsh_maddr", {22'd0, mem_addr}, 32'd0);
            chk("rsh_ready", {31'd0, req_ready}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("rsh_ready_after", {31'd0, req_ready}, 32'd1);
        $display("txn SH addr=00000012 aborted by reset in RD");
        do_load("lw_10", 3'b010, 32'h10, 32'h0BADF00D);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
